// File: rtl/carbon_arch_pkg.sv
// Carbon core architectural constants shared by the debug subsystem.
package carbon_arch_pkg;

    localparam logic [31:0] DBG_CTRL        = 32'h0000_0010;
    localparam logic [31:0] DBG_STATUS      = 32'h0000_0014;
    localparam logic [31:0] DBG_DATA0       = 32'h0000_0020;

    localparam int CARBON_DBG_ARB_TIMEOUT_DEFAULT = 256;

endpackage

// File: rtl/debug_csr_arbiter_pkg.sv
// Types and helpers for the debug CSR arbiter.
package debug_csr_arbiter_pkg;

    typedef struct packed {
        logic [31:0] rdata;
        logic        fault;
        logic        side_effect;
    } csr_rsp_t;

    localparam csr_rsp_t CSR_RSP_TIMEOUT = '{rdata: 32'h0, fault: 1'b1, side_effect: 1'b0};

    // Counter must hold TIMEOUT-1; keep at least one bit when the timeout is disabled.
    function automatic int dbg_arb_cnt_width(input int timeout);
        int w;
        w = $clog2(timeout + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/csr_if.sv
// Debug CSR request/response bundle between the arbiter and the debug hub.
interface csr_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;
    logic        rsp_side_effect;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_fault, rsp_side_effect
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_fault, rsp_side_effect
    );
endinterface

// File: rtl/debug_csr_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after ptr_i, wrapping modulo N_REQ.
module rr_pick #(
    parameter  int N_REQ = 2,
    localparam int GW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [GW-1:0]    ptr_i,
    output logic             any_o,
    output logic [GW-1:0]    idx_o
);
    localparam int PW = GW + 1;

    logic [GW-1:0]    cand [N_REQ];
    logic [N_REQ-1:0] rot;

    // cand[k] is the requester k positions after the pointer.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
        logic [PW-1:0] sum;
        logic [PW-1:0] sum_wrap;
        assign sum      = {1'b0, ptr_i} + PW'(gi);
        assign sum_wrap = sum - PW'(N_REQ);
        assign cand[gi] = (sum >= PW'(N_REQ)) ? sum_wrap[GW-1:0] : sum[GW-1:0];
        assign rot[gi]  = req_i[cand[gi]];
    end

    assign any_o = |req_i;

    always_comb begin
        idx_o = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                idx_o = cand[k];
            end
        end
    end
endmodule

// File: rtl/debug_csr_arbiter.sv
// Round-robin arbiter sharing the debug CSR port, one transaction in flight, with response timeout.
module debug_csr_arbiter
    import carbon_arch_pkg::*;
    import debug_csr_arbiter_pkg::*;
#(
    parameter  int N_REQ   = 2,
    parameter  int TIMEOUT = CARBON_DBG_ARB_TIMEOUT_DEFAULT,
    localparam int GW      = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   s_req_valid,
    output logic [N_REQ-1:0]   s_req_ready,
    input  logic [N_REQ-1:0]   s_req_write,
    input  logic [N_REQ*32-1:0] s_req_addr,
    input  logic [N_REQ*32-1:0] s_req_wdata,
    output logic [N_REQ-1:0]   s_rsp_valid,
    input  logic [N_REQ-1:0]   s_rsp_ready,
    output logic [31:0]        s_rsp_rdata,
    output logic               s_rsp_fault,
    output logic               s_rsp_side_effect,
    csr_if.master              m_csr,
    output logic               busy,
    output logic [GW-1:0]      grant_idx,
    output logic               timeout_pulse
);
    localparam int CW      = dbg_arb_cnt_width(TIMEOUT);
    localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    typedef enum logic [2:0] {IDLE, REQ, WAIT, RSP, RSP_TO, DRAIN} state_e;

    state_e        state_q, state_d;
    logic [GW-1:0] rr_ptr_q, rr_ptr_d;
    logic [GW-1:0] grant_q, grant_d;
    logic          write_q, write_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    csr_rsp_t      rsp_q, rsp_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pulse_q, pulse_d;

    logic          pick_any;
    logic [GW-1:0] pick_idx;
    logic [31:0]   addr_arr  [N_REQ];
    logic [31:0]   wdata_arr [N_REQ];
    logic          timeout_hit;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
        assign addr_arr[gi]  = s_req_addr[32*gi +: 32];
        assign wdata_arr[gi] = s_req_wdata[32*gi +: 32];
    end

    rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
        .req_i (s_req_valid),
        .ptr_i (rr_ptr_q),
        .any_o (pick_any),
        .idx_o (pick_idx)
    );

    // A response arriving in the expiry cycle still wins over the timeout.
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CW'(TO_LAST)) && !m_csr.rsp_valid;

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        write_d  = write_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rsp_d    = rsp_q;
        cnt_d    = cnt_q;
        pulse_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d  = pick_idx;
                    rr_ptr_d = (pick_idx == GW'(N_REQ - 1)) ? '0 : pick_idx + GW'(1);
                    write_d  = s_req_write[pick_idx];
                    addr_d   = addr_arr[pick_idx];
                    wdata_d  = wdata_arr[pick_idx];
                    state_d  = REQ;
                end
            end
            REQ: begin
                if (m_csr.req_ready) begin
                    cnt_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (m_csr.rsp_valid) begin
                    rsp_d   = '{rdata: m_csr.rsp_rdata, fault: m_csr.rsp_fault,
                                side_effect: m_csr.rsp_side_effect};
                    state_d = RSP;
                end else if (timeout_hit) begin
                    rsp_d   = CSR_RSP_TIMEOUT;
                    pulse_d = 1'b1;
                    state_d = RSP_TO;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RSP: begin
                if (s_rsp_ready[grant_q]) state_d = IDLE;
            end
            RSP_TO: begin
                if (s_rsp_ready[grant_q]) state_d = DRAIN;
            end
            DRAIN: begin
                if (m_csr.rsp_valid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            write_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rsp_q    <= '0;
            cnt_q    <= '0;
            pulse_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            write_q  <= write_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rsp_q    <= rsp_d;
            cnt_q    <= cnt_d;
            pulse_q  <= pulse_d;
        end
    end

    // Ready is gated by rst_n so a requester holding valid through reset sees no accept.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_port
        assign s_req_ready[gi] = rst_n && (state_q == IDLE) && pick_any && (pick_idx == GW'(gi));
        assign s_rsp_valid[gi] = ((state_q == RSP) || (state_q == RSP_TO)) && (grant_q == GW'(gi));
    end

    assign s_rsp_rdata       = rsp_q.rdata;
    assign s_rsp_fault       = rsp_q.fault;
    assign s_rsp_side_effect = rsp_q.side_effect;

    assign m_csr.req_valid = (state_q == REQ);
    assign m_csr.req_write = write_q;
    assign m_csr.req_addr  = addr_q;
    assign m_csr.req_wdata = wdata_q;
    assign m_csr.rsp_ready = (state_q == WAIT) || (state_q == DRAIN);

    assign busy          = (state_q != IDLE);
    assign grant_idx     = grant_q;
    assign timeout_pulse = pulse_q;
endmodule
